ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-Lite slave with on-chip word-addressed memory, programmable wait states and two-cycle ERROR response. It consumes the master-side transfer stream carried by the bench AHB interface and is the default synthesizable slave endpoint behind the AHB_Gen interconnect. Byte, halfword and word accesses are supported, little-endian.

## Interface
- ADDR_W, 32, haddr width
- DATA_W, 32, data bus width (fixed 32; hsize > 2 is an error)
- MEM_DEPTH, 256, number of 32-bit words; valid byte range 0 .. 4*MEM_DEPTH-1
- WAIT_STATES, 0, extra data-phase cycles per OKAY transfer (0..15)

- hclk  in  1  clock, all state updates on rising edge
- hresetn  in  1  asynchronous, active-low reset
- hsel  in  1  slave select
- haddr  in  ADDR_W  byte address
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  in  1  1 = write
- hsize  in  3  0 byte, 1 halfword, 2 word
- hburst  in  3  ignored (each beat handled independently)
- hwdata  in  DATA_W  write data, data phase
- hready  in  1  bus-level ready (previous transfer complete)
- hreadyout  out  1  slave ready
- hresp  out  1  0 OKAY, 1 ERROR
- hrdata  out  DATA_W  read data

## Operation
- Address phase accepted when hsel & hready & htrans[1]; captured: haddr, hwrite, hsize into addr_q/write_q/size_q.
- hsel & hready with htrans IDLE/BUSY, or !hsel: no access; zero-wait OKAY.
- Error check at acceptance (any true → ERROR, no memory access):
  - hsize > 2
  - word index haddr[ADDR_W-1:2] >= MEM_DEPTH
  - misalignment: hsize=1 with haddr[0]=1; hsize=2 with haddr[1:0]!=0
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=0. Valid accept → WAIT if WAIT_STATES>0 (counter loaded WAIT_STATES), else stays IDLE with access completing next cycle (single-cycle data phase, tracked by dphase_q flag). Error accept → ERR1.
  - WAIT: hreadyout=0, hresp=0, counter decrements; at counter==1 → IDLE with dphase_q set (final data-phase cycle, hreadyout=1).
  - ERR1: hreadyout=0, hresp=1 → ERR2.
  - ERR2: hreadyout=1, hresp=1 → IDLE; a new transfer presented in this cycle (hready=1) is accepted normally.
- Write: at the rising edge ending the final data-phase cycle, bytes selected by size_q/addr_q[1:0] from hwdata are written; other lanes unchanged.
- Read: during final data-phase cycle hrdata = mem[addr_q word] (full word, all lanes); otherwise hrdata = 0.
- A transfer accepted during the final data-phase cycle of the previous one is pipelined (back-to-back, no bubble when WAIT_STATES=0).
- Memory contents not reset.

## Timing
- Reset values: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, counter=0, dphase_q=0.
- OKAY data phase: WAIT_STATES+1 cycles; hreadyout low exactly WAIT_STATES cycles.
- ERROR: exactly 2 cycles (0/1 then 1/1 on hreadyout/hresp), independent of WAIT_STATES.
- Read-after-write same address, back-to-back: write commits at edge ending write data phase; following read data phase returns new data.
- hresetn asserted mid-transfer: all outputs to reset values asynchronously; pending write discarded.
- Address phase with hready=0 (another slave stalling): ignored even if hsel=1.

## Test plan
- Reset: hresetn=0 mid-WAIT → hreadyout=1, hresp=0, hrdata=0 immediately; no write to memory.
- WAIT_STATES=0: write word 0xDEADBEEF @0x10, then read @0x10 back-to-back → hreadyout never low, hrdata=0xDEADBEEF in read data phase.
- Byte/half lanes: word 0x00000000 @0x20, write byte 0xAA @0x21, half 0x5566 @0x22 → read @0x20 returns 0x5566AA00.
- WAIT_STATES=3: read @0x0 → hreadyout low 3 cycles, high on 4th with data; next NONSEQ accepted on that cycle.
- Errors: word @0x02, half @0x01, hsize=3 @0x0, word @4*MEM_DEPTH → each gives hreadyout/hresp 0/1 then 1/1, memory unchanged.
- IDLE/BUSY with hsel=1 and hready=0 transfers → OKAY, zero wait, no access.

Source files
------------

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master/interconnect
// and the on-chip SRAM slave.
interface ahb_sram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite,
    output hsize, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite,
    input  hsize, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word memory, byte lanes,
// programmable wait states, two-cycle ERROR.
module ahb_sram_slave #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic hclk,
  input  logic hresetn,
  ahb_sram_slave_if.slave bus
);
  localparam int IW =
    (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_ERR1, S_ERR2
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              dphase_q;
  logic              write_q;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic [IW-1:0]     idx_q;
  logic              hreadyout_q;
  logic              hresp_q;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic              accept;
  logic              err_size;
  logic              err_range;
  logic              err_align;
  logic              err;
  logic [ADDR_W-1:0] widx;
  logic [3:0]        be;
  logic              unused_hburst;

  assign unused_hburst = ^bus.hburst;

  // only sample a new address phase while we drive ready
  assign accept = bus.hsel & bus.hready &
                  bus.htrans[1] & hreadyout_q;

  assign widx = {2'b00, bus.haddr[ADDR_W-1:2]};

  assign err_size  = bus.hsize > 3'd2;
  assign err_range = widx >= ADDR_W'(MEM_DEPTH);
  assign err_align =
    ((bus.hsize == 3'd1) & bus.haddr[0]) |
    ((bus.hsize == 3'd2) & (|bus.haddr[1:0]));
  assign err = err_size | err_range | err_align;

  always_comb begin
    be = 4'b0000;
    unique case (1'b1)
      size_q == 2'd0: be = 4'b0001 << lane_q;
      size_q == 2'd1:
        be = lane_q[1] ? 4'b1100 : 4'b0011;
      size_q == 2'd2: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dphase_q    <= 1'b0;
      write_q     <= 1'b0;
      size_q      <= '0;
      lane_q      <= '0;
      idx_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      dphase_q <= 1'b0;
      unique case (state_q)
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q     <= S_IDLE;
            dphase_q    <= 1'b1;
            hreadyout_q <= 1'b1;
          end
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
          if (accept) begin
            write_q <= bus.hwrite;
            size_q  <= bus.hsize[1:0];
            lane_q  <= bus.haddr[1:0];
            idx_q   <= bus.haddr[IW+1:2];
            if (err) begin
              state_q     <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state_q     <= S_WAIT;
              cnt_q       <= 4'(WAIT_STATES);
              hreadyout_q <= 1'b0;
            end else begin
              dphase_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // hresetn gate drops a write caught by a reset pulse
  always_ff @(posedge hclk) begin
    if (hresetn && dphase_q && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx_q][8*i +: 8] <=
            bus.hwdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.hrdata =
    (dphase_q && !write_q) ? mem[idx_q] : '0;
  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Random + directed bench for ahb_sram_slave,
// one DUT with no wait states and one with three.
module tb_ahb_sram_slave;
  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic        hclk;
  logic        hresetn;
  logic        dsel;
  logic        nrdy;
  logic        m_sel;
  logic [1:0]  m_trans;
  logic        m_wr;
  logic [2:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        ro;
  logic        rr;
  logic [31:0] rd;

  int total = 0;
  int bad = 0;
  logic [31:0] last_rd;
  xfer_t q[$];

  logic [7:0] mb [2][1024];
  bit         kn [2][1024];

  ahb_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) b0();
  ahb_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) b3();

  ahb_sram_slave #(
    .ADDR_W(32), .DATA_W(32),
    .MEM_DEPTH(256), .WAIT_STATES(0)
  ) u_ws0 (
    .hclk(hclk), .hresetn(hresetn), .bus(b0)
  );

  ahb_sram_slave #(
    .ADDR_W(32), .DATA_W(32),
    .MEM_DEPTH(256), .WAIT_STATES(3)
  ) u_ws3 (
    .hclk(hclk), .hresetn(hresetn), .bus(b3)
  );

  assign b0.hsel   = m_sel & ~dsel;
  assign b3.hsel   = m_sel & dsel;
  assign b0.haddr  = m_addr;
  assign b3.haddr  = m_addr;
  assign b0.htrans = m_trans;
  assign b3.htrans = m_trans;
  assign b0.hwrite = m_wr;
  assign b3.hwrite = m_wr;
  assign b0.hsize  = m_size;
  assign b3.hsize  = m_size;
  assign b0.hburst = 3'd0;
  assign b3.hburst = 3'd0;
  assign b0.hwdata = m_wdata;
  assign b3.hwdata = m_wdata;
  assign b0.hready = b0.hreadyout & ~nrdy;
  assign b3.hready = b3.hreadyout & ~nrdy;

  assign ro = dsel ? b3.hreadyout : b0.hreadyout;
  assign rr = dsel ? b3.hresp : b0.hresp;
  assign rd = dsel ? b3.hrdata : b0.hrdata;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic xfer_t mk(
    logic sel, logic [1:0] tr, logic wr,
    logic [2:0] sz, logic [31:0] a,
    logic [31:0] d);
    xfer_t x;
    x.sel = sel; x.trans = tr; x.wr = wr;
    x.size = sz; x.addr = a; x.data = d;
    return x;
  endfunction

  function automatic bit is_err(xfer_t p);
    logic [31:0] am;
    am = (32'd1 << p.size) - 32'd1;
    return (p.size > 3'd2) ||
           ((p.addr >> 2) >= 32'd256) ||
           ((p.addr & am) != 32'd0);
  endfunction

  task automatic data_phase(xfer_t p);
    int d = dsel ? 1 : 0;
    int ws = dsel ? 3 : 0;
    int waits = 0;
    int guard = 0;
    bit done = 0;
    logic first_resp = 1'b0;
    bit acc = p.sel && p.trans[1];
    bit er = acc && is_err(p);
    int base;
    logic [31:0] exp;
    logic [31:0] msk;
    while (!done) begin
      @(negedge hclk);
      if (ro) begin
        done = 1;
      end else begin
        waits++;
        if (waits == 1) first_resp = rr;
        check("wait_rdata", rd, 32'd0);
      end
      if (!done) begin
        @(posedge hclk); #1;
        guard++;
        if (guard > 40) begin
          check("timeout", 32'd1, 32'd0);
          done = 1;
        end
      end
    end
    check("waits", waits,
          acc ? (er ? 1 : ws) : 0);
    check("resp", {31'd0, rr}, {31'd0, er});
    if (er) check("resp1", {31'd0, first_resp}, 1);
    if (!acc || er) check("no_rdata", rd, 0);
    if (acc && !er && !p.wr) begin
      base = int'(p.addr) & ~3;
      for (int b = 0; b < 4; b++) begin
        exp[8*b +: 8] = mb[d][base+b];
        msk[8*b +: 8] = kn[d][base+b] ? 8'hff : 8'h00;
      end
      check("rdata", rd & msk, exp & msk);
      last_rd = rd;
    end
    if (acc && !er && p.wr) begin
      for (int b = 0; b < (1 << p.size); b++) begin
        int a = int'(p.addr) + b;
        mb[d][a] = p.data[8*(a%4) +: 8];
        kn[d][a] = 1'b1;
      end
    end
    @(posedge hclk); #1;
  endtask

  task automatic run_q();
    xfer_t cur;
    xfer_t prv;
    bit have = 0;
    int n = q.size();
    for (int i = 0; i <= n; i++) begin
      cur = (i < n) ? q[i] : mk(0, 0, 0, 0, 0, 0);
      m_sel   = cur.sel;
      m_trans = cur.trans;
      m_wr    = cur.wr;
      m_size  = cur.size;
      m_addr  = cur.addr;
      m_wdata = have ? prv.data : 32'd0;
      if (have) data_phase(prv);
      else begin
        @(posedge hclk); #1;
      end
      prv = cur;
      have = 1;
    end
    m_sel = 0; m_trans = 0;
    q.delete();
  endtask

  function automatic xfer_t rnd_x();
    xfer_t x;
    int r = $urandom_range(0, 15);
    x.sel = (r != 0);
    x.trans = (r < 3) ? 2'($urandom_range(0, 1))
                      : 2'($urandom_range(2, 3));
    x.wr = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 9);
    x.size = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 :
             (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
    r = $urandom_range(0, 19);
    x.addr = (r == 0) ? $urandom()
                      : 32'($urandom_range(0, 1027));
    if ($urandom_range(0, 7) != 0 && x.size < 3)
      x.addr = x.addr & ~((32'd1 << x.size) - 1);
    x.data = $urandom();
    return x;
  endfunction

  initial begin
    hresetn = 0; dsel = 0; nrdy = 0;
    m_sel = 0; m_trans = 0; m_wr = 0;
    m_size = 0; m_addr = 0; m_wdata = 0;
    last_rd = 0;
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 1024; a++) kn[d][a] = 0;
    repeat (3) @(posedge hclk);
    #1;
    for (int d = 0; d < 2; d++) begin
      dsel = 1'(d); #1;
      check("rst_rdy", {31'd0, ro}, 1);
      check("rst_resp", {31'd0, rr}, 0);
      check("rst_rdata", rd, 0);
    end
    dsel = 0;
    @(negedge hclk); hresetn = 1;
    @(posedge hclk); #1;

    q.push_back(mk(1, 2, 1, 2, 32'h10, 32'hdeadbeef));
    q.push_back(mk(1, 2, 0, 2, 32'h10, 0));
    run_q();
    check("b2b_rd", last_rd, 32'hdeadbeef);

    q.push_back(mk(1, 2, 1, 2, 32'h20, 0));
    q.push_back(mk(1, 2, 1, 0, 32'h21, 32'haaaaaaaa));
    q.push_back(mk(1, 3, 1, 1, 32'h22, 32'h55665566));
    q.push_back(mk(1, 2, 0, 2, 32'h20, 0));
    run_q();
    check("lanes", last_rd, 32'h5566aa00);

    dsel = 1;
    q.push_back(mk(1, 2, 1, 2, 32'h0, 32'h0badf00d));
    q.push_back(mk(1, 2, 1, 2, 32'h10, 32'hcafe0001));
    q.push_back(mk(1, 2, 0, 2, 32'h0, 0));
    q.push_back(mk(1, 2, 0, 2, 32'h10, 0));
    run_q();
    check("ws3_rd", last_rd, 32'hcafe0001);

    for (int d = 0; d < 2; d++) begin
      dsel = 1'(d);
      q.push_back(mk(1, 2, 1, 2, 32'h0, 32'h11223344));
      q.push_back(mk(1, 2, 1, 2, 32'h2, 32'hffffffff));
      q.push_back(mk(1, 2, 1, 1, 32'h1, 32'hffffffff));
      q.push_back(mk(1, 2, 1, 3, 32'h0, 32'hffffffff));
      q.push_back(mk(1, 2, 1, 2, 32'd1024, 32'hffffffff));
      q.push_back(mk(1, 2, 0, 2, 32'h3, 0));
      q.push_back(mk(1, 2, 0, 2, 32'h0, 0));
      run_q();
      check("err_mem", last_rd, 32'h11223344);
      q.push_back(mk(1, 0, 1, 2, 32'h0, 32'h0));
      q.push_back(mk(1, 1, 1, 2, 32'h0, 32'h0));
      q.push_back(mk(0, 2, 1, 2, 32'h0, 32'h0));
      q.push_back(mk(1, 2, 0, 2, 32'h0, 0));
      run_q();
      check("idle_mem", last_rd, 32'h11223344);
    end

    dsel = 0;
    nrdy = 1; m_sel = 1; m_trans = 2'd2;
    m_wr = 1; m_size = 3'd2; m_addr = 32'h10;
    @(negedge hclk);
    check("nrdy_rdy", {31'd0, ro}, 1);
    @(posedge hclk); #1;
    nrdy = 0; m_sel = 0; m_trans = 0;
    m_wdata = 32'h12345678;
    @(negedge hclk);
    check("nrdy_rdy2", {31'd0, ro}, 1);
    check("nrdy_resp", {31'd0, rr}, 0);
    @(posedge hclk); #1;
    q.push_back(mk(1, 2, 0, 2, 32'h10, 0));
    run_q();
    check("nrdy_mem", last_rd, 32'hdeadbeef);

    dsel = 1;
    m_sel = 1; m_trans = 2'd2; m_wr = 1;
    m_size = 3'd2; m_addr = 32'h10;
    @(posedge hclk); #1;
    m_sel = 0; m_trans = 0; m_wdata = 32'h5a5a5a5a;
    @(negedge hclk);
    check("rst_inwait", {31'd0, ro}, 0);
    hresetn = 0; #1;
    check("arst_rdy", {31'd0, ro}, 1);
    check("arst_resp", {31'd0, rr}, 0);
    check("arst_rdata", rd, 0);
    repeat (4) @(posedge hclk);
    @(negedge hclk); hresetn = 1;
    @(posedge hclk); #1;
    q.push_back(mk(1, 2, 0, 2, 32'h10, 0));
    run_q();
    check("arst_mem", last_rd, 32'hcafe0001);

    for (int d = 0; d < 2; d++) begin
      dsel = 1'(d);
      for (int i = 0; i < 300; i++)
        q.push_back(rnd_x());
      run_q();
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
